fsk_demodulator: RTL
====================

// Module: fsk_demodulator
// PURPOSE
//  Receive-side stage directly downstream of FSKEncoder. Takes the serial 2-FSK waveform
//  and carrier-present flag on the quickclk domain, decides one bit per bit period by
//  counting rising edges of the waveform, and reassembles CODE_W-bit Hamming codewords.
//  Output words match what CodeSep serialised, MSB first; feeds the Hamming decoder.
// PARAMETERS
//  BIT_CYCLES   64   quickclk cycles per transmitted bit (must match FSKEncoder)
//  EDGE_THRESH  5    rising-edge count >= this in one bit window decides '1', else '0'
//  CODE_W       11   bits per codeword
// PORTS
//  quickclk    in   1       system clock; all logic on rising edge
//  reset       in   1       asynchronous, active-low reset
//  fskin       in   1       FSK waveform (FSKout of encoder)
//  sending     in   1       carrier-present; high while a word is on the line
//  code_out    out  CODE_W  last complete received codeword, bit CODE_W-1 received first
//  code_valid  out  1       one-cycle pulse: code_out updated this cycle
//  frame_err   out  1       one-cycle pulse: word aborted (sending fell mid-word)
//  code_err    out  1       valid with code_valid; Hamming syndrome non-zero (see CONFIG)
// BEHAVIOUR
//  - Reset (reset low, async): all outputs 0, state IDLE, counters/shift reg/syncs cleared.
//  - fskin and sending pass through 2-FF synchronisers (fs, ss); everything below uses them.
//  - Rising edge of fs = fs & ~fs_d (one extra flop). Edge counter saturates at all-ones.
//  - FSM states: IDLE, SAMPLE, DONE.
//    IDLE:   on ss rising edge -> SAMPLE; cyc_cnt=0, edge_cnt=0, bit_idx=0.
//    SAMPLE: cyc_cnt counts 0..BIT_CYCLES-1; edge_cnt += fs rising edge.
//            At cyc_cnt==BIT_CYCLES-1: bit=(edge_cnt_next>=EDGE_THRESH), shift into
//            shreg LSB (shreg<={shreg[CODE_W-2:0],bit}); cyc_cnt,edge_cnt->0; bit_idx++.
//            When bit_idx reaches CODE_W -> DONE.
//            If ss==0 at any SAMPLE cycle (before last shift): frame_err=1 one cycle,
//            partial word discarded, code_out unchanged -> IDLE.
//    DONE:   code_out<=shreg, code_valid=1 one cycle, code_err per CONFIG;
//            if ss still high -> SAMPLE (back-to-back word, counters cleared) else IDLE.
//  - An edge counted on the last window cycle is included in that bit's decision.
//  - Latency: code_valid asserted 1 cycle after last window closes (plus 2-cycle sync
//    delay relative to raw pins).
//  - sending falling on the same cycle as the last bit's final window cycle: word completes,
//    no frame_err; DONE then goes to IDLE.
//  - fskin activity while IDLE is ignored; edge counter width = clog2(BIT_CYCLES)+1.
//  - Reset asserted mid-word: immediate return to reset values, no pulse emitted.
// CONFIGURATION
//  FSKDEMOD_SYNDROME_EN defined: on DONE compute Hamming syndrome of shreg; position p
//   (1..CODE_W) is shreg[p-1]; parity positions 1,2,4,8; syndrome = XOR of all p with
//   bit set; code_err=1 with code_valid when syndrome!=0. Word is NOT corrected here.
//  Not defined: syndrome logic absent, code_err tied to 0.
// TESTING (BIT_CYCLES=64, EDGE_THRESH=5; '1' = fskin toggles every 4 cycles (8 edges),
//          '0' = toggles every 16 cycles (2 edges))
//  1 reset low 400ns then high, no stimulus -> all outputs 0, no pulses.
//  2 sending high for 11 bits of 11'b101_0101_0101 -> one code_valid, code_out=11'h555,
//    frame_err=0.
//  3 two words 11'h7FF then 11'h000 with sending held high -> two code_valid pulses
//    704 cycles apart, values 11'h7FF then 11'h000.
//  4 sending drops after 5 bits -> frame_err pulse once, no code_valid, code_out keeps
//    previous value; next full word received correctly.
//  5 window with exactly 4 edges -> bit 0; exactly 5 edges -> bit 1 (threshold boundary).
//  6 FSKDEMOD_SYNDROME_EN: send valid codeword 11'h000, then 11'h004 (pos 3 flipped) ->
//    code_err 0 then 1; without macro code_err stays 0 for both.

Source files
------------

// File: rtl/fsk_demodulator.sv
// 2-FSK receiver: counts rising edges of the synchronised waveform per bit window and
// reassembles CODE_W-bit codewords MSB first. Optional macro FSKDEMOD_SYNDROME_EN adds a Hamming syndrome check.
module fsk_demodulator #(
    parameter int BIT_CYCLES  = 64,
    parameter int EDGE_THRESH = 5,
    parameter int CODE_W      = 11
) (
    input  logic              quickclk,
    input  logic              reset,
    input  logic              fskin,
    input  logic              sending,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    output logic              frame_err,
    output logic              code_err
);
    localparam int CYC_W  = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int EDGE_W = $clog2(BIT_CYCLES) + 1;
    localparam int IDX_W  = $clog2(CODE_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_DONE} state_t;

    state_t            r_state;
    logic              r_fs_s1, r_fs, r_fs_d;
    logic              r_ss_s1, r_ss, r_ss_d;
    logic [CYC_W-1:0]  r_cyc_cnt;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    // Only the first CODE_W-1 bits need storing; the last bit joins them on the fly.
    logic [CODE_W-2:0] r_shreg;

    logic              w_fs_rise, w_ss_rise, w_last_cyc, w_last_bit, w_bit, w_syn_err;
    logic [EDGE_W-1:0] w_edge_next;
    logic [CODE_W-1:0] w_shreg_next;

    assign w_fs_rise    = r_fs & ~r_fs_d;
    assign w_ss_rise    = r_ss & ~r_ss_d;
    assign w_edge_next  = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + EDGE_W'(w_fs_rise);
    assign w_bit        = (w_edge_next >= EDGE_W'(EDGE_THRESH));
    assign w_last_cyc   = (r_cyc_cnt == CYC_W'(BIT_CYCLES - 1));
    assign w_last_bit   = (r_bit_idx == IDX_W'(CODE_W - 1));
    assign w_shreg_next = {r_shreg, w_bit};

`ifdef FSKDEMOD_SYNDROME_EN
    localparam int SYN_W = $clog2(CODE_W + 1);

    function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] w);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p <= CODE_W; p++)
            if (w[p-1]) s = s ^ SYN_W'(p);
        return s;
    endfunction

    assign w_syn_err = |syndrome(w_shreg_next);
`else
    assign w_syn_err = 1'b0;
`endif

    always_ff @(posedge quickclk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fs_s1    <= 1'b0;
            r_fs       <= 1'b0;
            r_fs_d     <= 1'b0;
            r_ss_s1    <= 1'b0;
            r_ss       <= 1'b0;
            r_ss_d     <= 1'b0;
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            r_fs_s1    <= fskin;
            r_fs       <= r_fs_s1;
            r_fs_d     <= r_fs;
            r_ss_s1    <= sending;
            r_ss       <= r_ss_s1;
            r_ss_d     <= r_ss;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ss_rise) begin
                        r_state    <= S_SAMPLE;
                        r_cyc_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                S_SAMPLE: begin
                    // Carrier may drop on the final window cycle without aborting the word.
                    if (!r_ss && !(w_last_cyc && w_last_bit)) begin
                        frame_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_last_cyc) begin
                        r_shreg    <= w_shreg_next[CODE_W-2:0];
                        r_cyc_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (w_last_bit) begin
                            code_out   <= w_shreg_next;
                            code_valid <= 1'b1;
                            code_err   <= w_syn_err;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        r_cyc_cnt  <= r_cyc_cnt + 1'b1;
                        r_edge_cnt <= w_edge_next;
                    end
                end
                S_DONE: begin
                    // DONE doubles as cycle 0 of a back-to-back word so windows stay aligned.
                    if (r_ss) begin
                        r_state    <= S_SAMPLE;
                        r_cyc_cnt  <= CYC_W'(1);
                        r_edge_cnt <= EDGE_W'(w_fs_rise);
                        r_bit_idx  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
